// File: rtl/periph_timer_pkg.sv
// Shared definitions for the periph_timer peripheral: register offsets,
// bit positions inside CTRL/STATUS and register reset values.
package periph_timer_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'd0;
    localparam logic [7:0] OFF_PRESCALE = 8'd1;
    localparam logic [7:0] OFF_COMPARE  = 8'd2;
    localparam logic [7:0] OFF_COUNT    = 8'd3;
    localparam logic [7:0] OFF_STATUS   = 8'd4;
    localparam logic [7:0] NUM_REGS     = 8'd5;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_AUTO    = 2;
    localparam int CTRL_ONESHOT = 3;

    localparam int STAT_MATCH = 0;
    localparam int STAT_OVF   = 1;

    localparam logic [3:0] RST_CTRL     = 4'h0;
    localparam logic [7:0] RST_PRESCALE = 8'h00;
    localparam logic [7:0] RST_COMPARE  = 8'hFF;
    localparam logic [7:0] RST_COUNT    = 8'h00;

endpackage

// File: rtl/periph_timer_if.sv
// CPU peripheral bus as seen by the timer: the CPU (master) drives address,
// write data and strobe; the peripheral (slave) returns read data, hit and irq.
interface periph_timer_if;

    logic [7:0] addr_ip;
    logic [7:0] data_ip;
    logic       we_ip;
    logic [7:0] data_op;
    logic       sel_op;
    logic       irq_op;

    modport master (
        output addr_ip, data_ip, we_ip,
        input  data_op, sel_op, irq_op
    );

    modport slave (
        input  addr_ip, data_ip, we_ip,
        output data_op, sel_op, irq_op
    );

endinterface

// File: rtl/periph_timer_prescaler.sv
// Prescaler: down-counter that emits a one-clock tick every prescale+1
// enabled clocks and rests at the programmed value while disabled or cleared.
module timer_prescaler
    import periph_timer_pkg::*;
(
    input  logic       clk_ip,
    input  logic       reset_n_ip,
    input  logic       en,
    input  logic [7:0] prescale,
    input  logic       clear,
    output logic       tick
);

    logic [7:0] r_cnt;

    assign tick = en & (r_cnt == 8'd0);

    // prescale is only sampled on reload, so a new value waits for the next period
    always_ff @(posedge clk_ip or negedge reset_n_ip) begin
        if (!reset_n_ip) begin
            r_cnt <= RST_PRESCALE;
        end else if (!en || clear || tick) begin
            r_cnt <= prescale;
        end else begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

endmodule

// File: rtl/periph_timer.sv
// Memory-mapped 8-bit timer/counter with compare match, overflow, one-shot and
// auto-reload modes; raises a registered level interrupt to the CPU.
module periph_timer
    import periph_timer_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic           clk_ip,
    input  logic           reset_n_ip,
    periph_timer_if.slave  bus
);

    logic [3:0] r_ctrl;
    logic [7:0] r_prescale;
    logic [7:0] r_compare;
    logic [7:0] r_count;
    logic       r_match;
    logic       r_ovf;
    logic       r_irq;

    logic [7:0] w_off;
    logic       w_sel;
    logic       w_wr_ctrl;
    logic       w_wr_prescale;
    logic       w_wr_compare;
    logic       w_wr_count;
    logic       w_wr_status;
    logic       w_tick;
    logic       w_tick_use;
    logic       w_match_set;
    logic       w_ovf_set;
    logic [3:0] w_ctrl_next;
    logic [7:0] w_count_next;
    logic [7:0] w_rdata;

    // Offset arithmetic wraps, so a single unsigned compare covers the window
    assign w_off = bus.addr_ip - BASE_ADDR;
    assign w_sel = (w_off < NUM_REGS);

    assign w_wr_ctrl     = bus.we_ip & w_sel & (w_off == OFF_CTRL);
    assign w_wr_prescale = bus.we_ip & w_sel & (w_off == OFF_PRESCALE);
    assign w_wr_compare  = bus.we_ip & w_sel & (w_off == OFF_COMPARE);
    assign w_wr_count    = bus.we_ip & w_sel & (w_off == OFF_COUNT);
    assign w_wr_status   = bus.we_ip & w_sel & (w_off == OFF_STATUS);

    timer_prescaler u_prescaler (
        .clk_ip     (clk_ip),
        .reset_n_ip (reset_n_ip),
        .en         (r_ctrl[CTRL_EN]),
        .prescale   (r_prescale),
        .clear      (w_wr_count),
        .tick       (w_tick)
    );

    // A COUNT load or a CTRL write that stops the timer swallows a coincident tick
    assign w_tick_use = w_tick & ~w_wr_count & ~(w_wr_ctrl & ~bus.data_ip[CTRL_EN]);

    always_comb begin
        w_ctrl_next  = r_ctrl;
        w_count_next = r_count;
        w_match_set  = 1'b0;
        w_ovf_set    = 1'b0;
        if (w_tick_use) begin
            if (r_count == r_compare) begin
                w_match_set = 1'b1;
                if (r_ctrl[CTRL_AUTO]) begin
                    w_count_next = 8'h00;
                end else begin
                    w_count_next = r_count + 8'd1;
                    w_ovf_set    = (r_count == 8'hFF);
                end
                if (r_ctrl[CTRL_ONESHOT]) begin
                    w_ctrl_next[CTRL_EN] = 1'b0;
                end
            end else begin
                w_count_next = r_count + 8'd1;
                w_ovf_set    = (r_count == 8'hFF);
            end
        end
        if (w_wr_ctrl) begin
            w_ctrl_next = bus.data_ip[3:0];
        end
        if (w_wr_count) begin
            w_count_next = bus.data_ip;
        end
    end

    always_ff @(posedge clk_ip or negedge reset_n_ip) begin
        if (!reset_n_ip) begin
            r_ctrl     <= RST_CTRL;
            r_prescale <= RST_PRESCALE;
            r_compare  <= RST_COMPARE;
            r_count    <= RST_COUNT;
            r_match    <= 1'b0;
            r_ovf      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_ctrl  <= w_ctrl_next;
            r_count <= w_count_next;
            if (w_wr_prescale) r_prescale <= bus.data_ip;
            if (w_wr_compare)  r_compare  <= bus.data_ip;
            // Hardware set has priority over a same-cycle write-1-to-clear
            r_match <= (r_match & ~(w_wr_status & bus.data_ip[STAT_MATCH])) | w_match_set;
            r_ovf   <= (r_ovf   & ~(w_wr_status & bus.data_ip[STAT_OVF]))   | w_ovf_set;
            r_irq   <= r_ctrl[CTRL_IE] & (r_match | r_ovf);
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        if (w_sel) begin
            case (w_off)
                OFF_CTRL:     w_rdata = {4'h0, r_ctrl};
                OFF_PRESCALE: w_rdata = r_prescale;
                OFF_COMPARE:  w_rdata = r_compare;
                OFF_COUNT:    w_rdata = r_count;
                OFF_STATUS:   w_rdata = {6'h00, r_ovf, r_match};
                default:      w_rdata = 8'h00;
            endcase
        end
    end

    assign bus.data_op = w_rdata;
    assign bus.sel_op  = w_sel;
    assign bus.irq_op  = r_irq;

endmodule

// File: tb/tb_periph_timer.sv
// Directed bench for periph_timer: expected values are queued when a step is
// driven and popped when the corresponding DUT output is sampled.
`timescale 1ns/1ps
module tb_periph_timer;

    localparam logic [7:0] BASE = 8'h10;

    logic clk;
    logic rst_n;

    periph_timer_if bus ();

    periph_timer #(.BASE_ADDR(BASE)) dut (
        .clk_ip     (clk),
        .reset_n_ip (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic expect_push(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic compare_pop(input logic [7:0] obs);
        exp_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %02h required an entry", obs);
        end else begin
            e = sb_q.pop_front();
            $display("vec %0d %s: observed %02h expected %02h", n_vec, e.tag, obs, e.val);
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %02h expected %02h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        expect_push(tag, exp);
        compare_pop(obs);
    endtask

    task automatic rd(input logic [7:0] off, input logic [7:0] exp, input string tag);
        bus.addr_ip = BASE + off;
        bus.we_ip   = 1'b0;
        expect_push(tag, exp);
        #1;
        compare_pop(bus.data_op);
    endtask

    // Each write consumes exactly one rising edge and returns 1ns after it
    task automatic wr(input logic [7:0] off, input logic [7:0] data);
        bus.addr_ip = BASE + off;
        bus.data_ip = data;
        bus.we_ip   = 1'b1;
        @(posedge clk);
        #1;
        bus.we_ip   = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.addr_ip = 8'h00;
        bus.data_ip = 8'h00;
        bus.we_ip   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);

        // Reset values, decode window and miss behaviour
        rd(8'd0, 8'h00, "rst_ctrl");
        rd(8'd1, 8'h00, "rst_prescale");
        rd(8'd2, 8'hFF, "rst_compare");
        rd(8'd3, 8'h00, "rst_count");
        rd(8'd4, 8'h00, "rst_status");
        chk("sel_hit", {7'd0, bus.sel_op}, 8'h01);
        rd(8'd5, 8'h00, "miss_data");
        chk("sel_miss", {7'd0, bus.sel_op}, 8'h00);
        chk("rst_irq", {7'd0, bus.irq_op}, 8'h00);
        wr(8'd0, 8'hF0);
        rd(8'd0, 8'h00, "ctrl_rz_bits");
        wr(8'd5, 8'h55);
        rd(8'd2, 8'hFF, "miss_write_ignored");

        // Compare match with interrupt
        wr(8'd1, 8'h00);
        wr(8'd2, 8'h05);
        wr(8'd0, 8'h03);
        rd(8'd3, 8'h00, "m_count0");
        step(5);
        rd(8'd3, 8'h05, "m_count5");
        rd(8'd4, 8'h00, "m_status_pre");
        step(1);
        rd(8'd4, 8'h01, "m_status_match");
        rd(8'd3, 8'h06, "m_count6");
        chk("m_irq_not_yet", {7'd0, bus.irq_op}, 8'h00);
        step(1);
        chk("m_irq_high", {7'd0, bus.irq_op}, 8'h01);
        wr(8'd4, 8'h01);
        rd(8'd4, 8'h00, "m_status_cleared");
        chk("m_irq_still_high", {7'd0, bus.irq_op}, 8'h01);
        step(1);
        chk("m_irq_low", {7'd0, bus.irq_op}, 8'h00);
        wr(8'd0, 8'h00);
        wr(8'd4, 8'h03);

        // Prescaled overflow with IE=0
        wr(8'd1, 8'h03);
        wr(8'd3, 8'hFE);
        wr(8'd0, 8'h01);
        step(3);
        rd(8'd3, 8'hFE, "o_count_fe");
        step(1);
        rd(8'd3, 8'hFF, "o_count_ff");
        rd(8'd4, 8'h00, "o_status_pre");
        step(3);
        rd(8'd3, 8'hFF, "o_count_ff_hold");
        step(1);
        rd(8'd3, 8'h00, "o_count_wrap");
        rd(8'd4, 8'h02, "o_status_ovf");
        chk("o_irq_masked", {7'd0, bus.irq_op}, 8'h00);
        wr(8'd0, 8'h00);
        wr(8'd4, 8'h03);
        rd(8'd4, 8'h00, "o_status_cleared");

        // One-shot with auto-reload
        wr(8'd1, 8'h00);
        wr(8'd3, 8'h00);
        wr(8'd2, 8'h02);
        wr(8'd0, 8'h0D);
        step(1);
        rd(8'd3, 8'h01, "a_count1");
        step(1);
        rd(8'd3, 8'h02, "a_count2");
        step(1);
        rd(8'd3, 8'h00, "a_count_reload");
        rd(8'd4, 8'h01, "a_status_match");
        rd(8'd0, 8'h0C, "a_ctrl_en_cleared");
        step(5);
        rd(8'd3, 8'h00, "a_count_hold");
        wr(8'd4, 8'h03);

        // Same-cycle W1C vs match, COUNT write vs tick, EN clear vs tick
        wr(8'd2, 8'h03);
        wr(8'd3, 8'h00);
        wr(8'd0, 8'h01);
        step(3);
        wr(8'd4, 8'h01);
        rd(8'd4, 8'h01, "s_set_beats_w1c");
        rd(8'd3, 8'h04, "s_count4");
        wr(8'd4, 8'h01);
        rd(8'd4, 8'h00, "s_status_cleared");
        wr(8'd2, 8'h07);
        step(1);
        rd(8'd3, 8'h07, "s_count7");
        wr(8'd3, 8'h80);
        rd(8'd3, 8'h80, "s_count_write_wins");
        rd(8'd4, 8'h00, "s_no_flag_from_tick");
        wr(8'd0, 8'h00);
        rd(8'd3, 8'h80, "s_en_clear_drops_tick");

        // Asynchronous reset between clock edges
        wr(8'd3, 8'h00);
        wr(8'd2, 8'h00);
        wr(8'd0, 8'h03);
        step(2);
        chk("r_irq_before", {7'd0, bus.irq_op}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_irq_async", {7'd0, bus.irq_op}, 8'h00);
        rd(8'd0, 8'h00, "r_ctrl");
        rd(8'd1, 8'h00, "r_prescale");
        rd(8'd2, 8'hFF, "r_compare");
        rd(8'd3, 8'h00, "r_count");
        rd(8'd4, 8'h00, "r_status");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2);
        rd(8'd3, 8'h00, "r_count_idle");
        chk("r_irq_idle", {7'd0, bus.irq_op}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
